uart_tx_engine: RTL

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_tx_engine.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding and defaults for the UART transmit engine.
// Defining UART_TX_PARITY_EN adds the PARITY state to the frame.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud ticks within one serial bit and flags the tick that ends it.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int oversample = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic baud_tick_i,
  output logic bit_end_o
);

  localparam int CW = (oversample > 1) ? $clog2(oversample) : 1;
  localparam logic [CW-1:0] LAST = CW'(oversample - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && baud_tick_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && baud_tick_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: pops bytes from an upstream FIFO and serialises them.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int data_wd    = 8,
  parameter int oversample = DEFAULT_OVERSAMPLE,
  parameter int stop_bits  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               baud_tick,
  input  logic               fifo_empty,
  input  logic [data_wd-1:0] fifo_rd_data,
  output logic               fifo_rd_en,
  input  logic               parity_odd,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int BW = $clog2(data_wd);
  localparam logic [BW-1:0] LAST_DATA = BW'(data_wd - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(stop_bits - 1);

  tx_state_e          state_q;
  logic [data_wd-1:0] shift_q;
  logic [BW-1:0]      bit_cnt_q;
  logic               tx_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_en_q;
  logic               bit_end;
  logic               timer_clr;
  logic               timer_en;

`ifdef UART_TX_PARITY_EN
  logic par_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Ticks seen while fetching or loading never count toward the start bit.
  assign timer_clr = (state_q == ST_LOAD);
  assign timer_en  = !(state_q inside {ST_IDLE, ST_FETCH, ST_LOAD});

  uart_bit_timer #(.oversample(oversample)) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (timer_clr),
    .en_i       (timer_en),
    .baud_tick_i(baud_tick),
    .bit_end_o  (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          shift_q   <= fifo_rd_data;
          bit_cnt_q <= '0;
          tx_q      <= 1'b0;
          state_q   <= ST_START;
`ifdef UART_TX_PARITY_EN
          par_q     <= (^fifo_rd_data) ^ parity_odd;
`endif
        end
        ST_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q      <= par_q;
              state_q   <= ST_PARITY;
`else
              tx_q      <= 1'b1;
              state_q   <= ST_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              tx_q      <= shift_q[1];
              shift_q   <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              done_q    <= 1'b1;
              // Chain straight into the next frame when data is waiting.
              if (!fifo_empty) begin
                rd_en_q <= 1'b1;
                state_q <= ST_FETCH;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign fifo_rd_en = rd_en_q;

endmodule
